ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 keyboard receiver, fully synchronous to the system clock, with a FIFO on the output. It oversamples `kclk`/`kdata`, glitch-filters them, and decodes the 11-bit device-to-host frame: odd parity check, stop-bit check and an inter-edge timeout. `E0`/`F0` prefixes are folded into flag bits, so each FIFO entry is one complete key event. It sits between the board PS/2 pins and the peripheral bus controller and replaces the edge-clocked receiver in the peripheral subsystem.

## Interface

Reset is asynchronous, active-low (`rst_n`), on the single clock `clk`.

Parameters:
- `FILTER_LEN`, 20: consecutive identical samples needed before a filtered line changes; ≥2.
- `TIMEOUT_CYC`, 100000: `clk` cycles allowed between falling `kclk` edges inside a frame.
- `FIFO_DEPTH`, 8: number of entries; power of two, ≥2.
- `PARITY_CHECK`, 1: 1 = frames with bad parity are rejected; 0 = parity is ignored.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `kclk`, in, 1: PS/2 clock pin, asynchronous.
- `kdata`, in, 1: PS/2 data pin, asynchronous.
- `rd_data`, out, 10: FIFO head. `[9]` = extended (`E0` seen), `[8]` = release (`F0` seen), `[7:0]` = scancode.
- `rd_valid`, out, 1: FIFO non-empty.
- `rd_ready`, in, 1: pop on `rd_valid && rd_ready`.
- `count`, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- `parity_err`, out, 1: one-cycle pulse.
- `frame_err`, out, 1: one-cycle pulse on a bad start, bad stop or timeout.
- `overflow`, out, 1: one-cycle pulse when an event is dropped.

## Operation

- **Input conditioning:** each line goes through a 2-FF synchronizer and then a filter. The filtered output takes the new value after `FILTER_LEN` consecutive equal samples. Filtered outputs reset to 1.
- **Edge detect:** a bit event is a 1→0 transition of filtered `kclk`. Filtered `kdata` is sampled in the same cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: event with data 0 → DATA, bit counter cleared. Event with data 1 → stays IDLE and pulses `frame_err`.
  - DATA: 8 events, shifted in LSB first → PARITY.
  - PARITY: bit stored → STOP.
  - STOP: event → IDLE. Data 0 → `frame_err`, byte discarded. Else, if `PARITY_CHECK` and (popcount(byte) + parity bit) is even → `parity_err`, byte discarded. Else the byte is accepted.
- **Timeout:** the counter clears on every event and counts while not in IDLE. At `TIMEOUT_CYC` the FSM returns to IDLE and pulses `frame_err`. A partial byte is discarded.
- **Prefix assembly on an accepted byte:**
  - `E0` sets `ext`, no push.
  - `F0` sets `rel`, no push.
  - Any other byte, including `E1`, pushes {`ext`, `rel`, byte} and clears both flags.
  - Every error (parity, frame, timeout) also clears both flags.
- **FIFO:** first-word-fall-through; `rd_data` shows the head whenever `rd_valid` is high.
  - Push while full with no pop in the same cycle: event dropped, `overflow` pulses, contents unchanged.
  - Push and pop in the same cycle while full: both are accepted, `count` unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Reset (asynchronous, mid-frame allowed):** FSM to IDLE, flags cleared, FIFO empty, `count`=0, `rd_valid`=0, `rd_data`=0, all pulses 0, filters to 1, timeout counter 0.

## Timing

- Pin change to filtered change: 2 + `FILTER_LEN` cycles.
- Filtered `kclk` falling edge to event: 1 cycle.
- Stop-bit event to `rd_valid` high (when the FIFO was empty): 1 cycle.
- Error pulses are asserted in the cycle after the offending event or timeout.
- `count` and `rd_valid` update the cycle after a push or pop.
- `rd_data` changes only on a push into an empty FIFO or on a pop.
- PS/2 bit period is ≥60 µs, so `FILTER_LEN` must stay well below half a bit period in `clk` cycles. At the defaults this is not a concern.

## Structure

- **Package `ps2_pkg`:**
  - FSM state enum.
  - Constants `PS2_EXT_CODE`=8'hE0 and `PS2_REL_CODE`=8'hF0.
  - Field positions `EXT_BIT`=9 and `REL_BIT`=8.
- **Sub-module `ps2_line_filter`:** synchronizer plus `FILTER_LEN` filter, instantiated twice (clock and data).
- **Inline:** the FIFO is inline register-array logic in `ps2_rx_fifo`.

## Test plan

1. Frame for 0x1C (data bits LSB first 0,0,1,1,1,0,0,0; parity 0; stop 1), `rd_ready`=0 → `rd_valid`=1, `rd_data`=10'h01C, `count`=1, no error pulses.
2. Byte sequences E0,75 / F0,1C / E0,F0,75 → exactly three entries: 10'h275, 10'h11C, 10'h375, in order.
3. 0x1C sent with parity 1 → `parity_err` pulses once, FIFO stays empty. After E0 followed by a bad-parity frame and then a good 0x75 → entry is 10'h075 (prefix cleared).
4. `kclk` stops after 4 data bits for `TIMEOUT_CYC` cycles → `frame_err` pulses once, FSM is in IDLE. A following good 0x1C frame → 10'h01C.
5. `FIFO_DEPTH`+1 frames 0x01..0x09 with `rd_ready`=0 → `overflow` pulses on the last frame, `count`=`FIFO_DEPTH`. Draining returns 0x01..0x08 in order. Push and pop in the same cycle while full keeps `count`=`FIFO_DEPTH` with no overflow.
6. `kclk` low glitch of `FILTER_LEN`-2 cycles → no event, no error. `rst_n` pulsed low mid-frame → all outputs at reset values immediately. A subsequent full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0]  PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0]  PS2_REL_CODE = 8'hF0;
  localparam int unsigned EXT_BIT      = 9;
  localparam int unsigned REL_BIT      = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter.
// The output only follows the synchronized line after FILTER_LEN
// consecutive samples that differ from the current output.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_line
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;

  // Synchronize the pin and accept a new level only after a stable run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_filt  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_line = r_filt;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered pins, frame decode with parity,
// stop and timeout checks, E0/F0 prefix folding, and a FWFT event FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN   = 20,
  parameter int unsigned TIMEOUT_CYC  = 100000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned PARITY_CHECK = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         kclk,
  input  logic                         kdata,
  output logic [9:0]                   rd_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         parity_err,
  output logic                         frame_err,
  output logic                         overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic            w_kclk_f;
  logic            w_kdata_f;
  logic            r_kclk_d;
  logic            r_event;
  logic            r_ev_data;
  ps2_state_e      r_state;
  ps2_state_e      w_next;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [TW-1:0]   r_to_cnt;
  logic            w_timeout;
  logic            w_frame_err;
  logic            w_parity_err;
  logic            w_accept;
  logic            w_push;
  logic [9:0]      w_wdata;
  logic            r_ext;
  logic            r_rel;
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;
  logic            r_parity_err;
  logic            r_frame_err;
  logic            r_overflow;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (kclk),
    .o_line (w_kclk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (kdata),
    .o_line (w_kdata_f)
  );

  // Falling edge of filtered kclk becomes a registered bit event with its data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kclk_d  <= 1'b1;
      r_event   <= 1'b0;
      r_ev_data <= 1'b1;
    end else begin
      r_kclk_d  <= w_kclk_f;
      r_event   <= r_kclk_d & ~w_kclk_f;
      r_ev_data <= w_kdata_f;
    end
  end

  assign w_timeout = (r_state != ST_IDLE) && !r_event &&
                     (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic; a timeout always returns to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (r_event && !r_ev_data)          w_next = ST_DATA;
      ST_DATA:   if (r_event && r_bitcnt == 3'd7)    w_next = ST_PARITY;
      ST_PARITY: if (r_event)                        w_next = ST_STOP;
      ST_STOP:   if (r_event)                        w_next = ST_IDLE;
      default:                                       w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_IDLE;
  end

  // FSM outputs: frame verdicts at the start and stop bits
  always_comb begin
    w_frame_err  = w_timeout;
    w_parity_err = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: if (r_event && r_ev_data) w_frame_err = 1'b1;
      ST_STOP: begin
        if (r_event) begin
          if (!r_ev_data)
            w_frame_err = 1'b1;
          else if ((PARITY_CHECK != 0) && !(^{r_shift, r_par}))
            w_parity_err = 1'b1;
          else
            w_accept = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bit counter, shift register, parity bit and inter-edge timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      if (r_event || r_state == ST_IDLE || w_timeout) r_to_cnt <= '0;
      else                                            r_to_cnt <= r_to_cnt + TW'(1);
      case (r_state)
        ST_IDLE: if (r_event && !r_ev_data) r_bitcnt <= '0;
        ST_DATA: if (r_event) begin
          r_shift  <= {r_ev_data, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        ST_PARITY: if (r_event) r_par <= r_ev_data;
        default: ;
      endcase
    end
  end

  assign w_push = w_accept && (r_shift != PS2_EXT_CODE) && (r_shift != PS2_REL_CODE);

  always_comb begin
    w_wdata          = {2'b00, r_shift};
    w_wdata[EXT_BIT] = r_ext;
    w_wdata[REL_BIT] = r_rel;
  end

  // Prefix flags: set by E0/F0, consumed by the next pushed byte, cleared on errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext <= 1'b0;
      r_rel <= 1'b0;
    end else if (w_frame_err || w_parity_err) begin
      r_ext <= 1'b0;
      r_rel <= 1'b0;
    end else if (w_accept) begin
      if (r_shift == PS2_EXT_CODE)      r_ext <= 1'b1;
      else if (r_shift == PS2_REL_CODE) r_rel <= 1'b1;
      else begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end
    end
  end

  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = rd_ready && (r_count != '0);
  assign w_wr   = w_push && (!w_full || w_pop);

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Registered one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_parity_err <= w_parity_err;
      r_frame_err  <= w_frame_err;
      r_overflow   <= w_push && w_full && !w_pop;
    end
  end

  assign rd_data    = r_mem[r_rptr];
  assign rd_valid   = (r_count != '0);
  assign count      = r_count;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed plus randomized bench for ps2_rx_fifo with a queue-based key-event model.
module tb_ps2_rx_fifo;

  localparam int FL    = 4;
  localparam int TO    = 400;
  localparam int DEPTH = 8;
  localparam int HALF  = 20;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          kclk = 1'b1;
  logic          kdata = 1'b1;
  logic          rd_ready = 1'b0;
  logic [9:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;

  ps2_rx_fifo #(
    .FILTER_LEN   (FL),
    .TIMEOUT_CYC  (TO),
    .FIFO_DEPTH   (DEPTH),
    .PARITY_CHECK (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kclk       (kclk),
    .kdata      (kdata),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pe_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int exp_pe = 0, exp_fe = 0, exp_ov = 0;
  logic [9:0] exp_q[$];
  bit m_ext = 0, m_rel = 0;

  // Count high cycles of each pulse output
  always @(negedge clk) begin
    if (parity_err) pe_cnt++;
    if (frame_err)  fe_cnt++;
    if (overflow)   ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input bit d, input bit pop_at_edge);
    kdata = d;
    cyc(HALF);
    kclk = 1'b0;
    if (pop_at_edge) begin
      // push lands FL+4 edges after the pin falls
      cyc(FL + 3);
      rd_ready = 1'b1;
      cyc(1);
      rd_ready = 1'b0;
      cyc(HALF - FL - 4);
    end else begin
      cyc(HALF);
    end
    kclk = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit pop);
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (bad_stop) begin
      exp_fe++; m_ext = 0; m_rel = 0;
    end else if (bad_par) begin
      exp_pe++; m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_rel, b});
      else exp_ov++;
      m_ext = 0; m_rel = 0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, count, exp_q.size());
    chk({tag, ".valid"}, rd_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk({tag, ".data"}, rd_data, exp_q[0]);
    chk({tag, ".perr"}, pe_cnt, exp_pe);
    chk({tag, ".ferr"}, fe_cnt, exp_fe);
    chk({tag, ".ovf"},  ov_cnt, exp_ov);
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input bit bad_par = 0,
                       input bit bad_stop = 0, input bit pop = 0);
    model_frame(b, bad_par, bad_stop, pop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ bad_par, 1'b0);
    ps2_bit(~bad_stop, pop);
    kdata = 1'b1;
    cyc(10);
    check_state(tag);
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".dvalid"}, rd_valid, 1);
      chk({tag, ".ddata"}, rd_data, exp_q[0]);
      rd_ready = 1'b1;
      cyc(1);
      rd_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    chk({tag, ".dcount"}, count, 0);
    chk({tag, ".dempty"}, rd_valid, 0);
  endtask

  initial begin
    logic [7:0] rb;
    bit bp, bs;

    // reset values
    cyc(3);
    chk("rst.valid", rd_valid, 0);
    chk("rst.count", count, 0);
    chk("rst.data", rd_data, 0);
    chk("rst.pulses", {parity_err, frame_err, overflow}, 0);
    rst_n = 1'b1;
    cyc(5);

    // 1: single make code
    frame("t1", 8'h1C);
    drain("t1");

    // 2: prefix folding
    frame("t2a", 8'hE0); frame("t2b", 8'h75);
    frame("t2c", 8'hF0); frame("t2d", 8'h1C);
    frame("t2e", 8'hE0); frame("t2f", 8'hF0); frame("t2g", 8'h75);
    chk("t2.n", count, 3);
    drain("t2");

    // 3: parity error discards byte and clears prefix
    frame("t3a", 8'h1C, 1);
    frame("t3b", 8'hE0);
    frame("t3c", 8'h1C, 1);
    frame("t3d", 8'h75);
    drain("t3");

    // 4: timeout after four data bits
    frame("t4p", 8'hF0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i >= 2, 1'b0);
    kdata = 1'b1;
    cyc(TO + 60);
    exp_fe++; m_ext = 0; m_rel = 0;
    check_state("t4to");
    frame("t4", 8'h1C);
    drain("t4");

    // 5: overflow, drain, then push+pop while full
    for (int i = 1; i <= DEPTH + 1; i++) frame("t5fill", 8'(i));
    chk("t5.ovf", ov_cnt, 1);
    drain("t5");
    for (int i = 0; i < DEPTH; i++) frame("t5refill", 8'(8'h11 + i));
    frame("t5pp", 8'h0A, 0, 0, 1);
    chk("t5pp.count", count, DEPTH);
    drain("t5pp");

    // 6: short glitch, start with data 1, bad stop, mid-frame reset
    kclk = 1'b0; cyc(FL - 2); kclk = 1'b1; cyc(20);
    check_state("t6glitch");
    frame("t6e0", 8'hE0);
    ps2_bit(1'b1, 1'b0); kdata = 1'b1; cyc(10);
    exp_fe++; m_ext = 0; m_rel = 0;
    check_state("t6start");
    frame("t6stop", 8'h33, 0, 1);
    frame("t6pre", 8'h2A);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t6rst.valid", rd_valid, 0);
    chk("t6rst.count", count, 0);
    chk("t6rst.data", rd_data, 0);
    chk("t6rst.pulses", {parity_err, frame_err, overflow}, 0);
    exp_q.delete(); m_ext = 0; m_rel = 0;
    kdata = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    frame("t6post", 8'h1C);
    drain("t6");

    // randomized traffic against the model
    for (int r = 0; r < 20; r++) begin
      case ($urandom_range(0, 3))
        0:       rb = 8'hE0;
        1:       rb = 8'hF0;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      bp = ($urandom_range(0, 7) == 0);
      bs = !bp && ($urandom_range(0, 9) == 0);
      frame("rnd", rb, bp, bs);
      if (exp_q.size() >= 6) drain("rnd");
    end
    drain("rndend");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
